// File: rtl/fetch_control_if.sv
// Fetch/decode bus: instruction-memory req/ack handshake plus the decoded control fields
// exchanged with the register-file/ALU datapath.
interface fetch_control_if #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
);
  localparam int RIDX = $clog2(NREGS);

  logic                  imem_req;
  logic [NBITS-1:0]      imem_addr;
  logic                  imem_ack;
  logic [31:0]           imem_rdata;
  logic [RIDX-1:0]       RS1;
  logic [RIDX-1:0]       RS2;
  logic [RIDX-1:0]       RD;
  logic [NBITS-1:0]      IMM;
  logic [WIDTH_ALUF-1:0] ALUControl;
  logic                  ALUSrc;
  logic                  MemtoReg;
  logic                  RegWrite;
  logic                  MemWrite;
  logic                  link;
  logic [NBITS-1:0]      pclink;
  logic                  Zero;
  logic [NBITS-1:0]      PCReg;

  modport master (
    output imem_req, imem_addr, RS1, RS2, RD, IMM, ALUControl,
           ALUSrc, MemtoReg, RegWrite, MemWrite, link, pclink,
    input  imem_ack, imem_rdata, Zero, PCReg
  );

  modport slave (
    input  imem_req, imem_addr, RS1, RS2, RD, IMM, ALUControl,
           ALUSrc, MemtoReg, RegWrite, MemWrite, link, pclink,
    output imem_ack, imem_rdata, Zero, PCReg
  );
endinterface

// File: rtl/fetch_control.sv
// Multi-cycle fetch + decode controller: owns the PC, fetches one RV32I-subset word at a time
// and presents decoded control for a single EXEC cycle.
//  state   | meaning
//  S_FETCH | raise imem_req for the current PC
//  S_WAIT  | hold request/address until imem_ack, capture the word into IR
//  S_EXEC  | decoded controls valid for one cycle, PC advances on exit
module fetch_control #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic            clock,
  input  logic            reset,
  fetch_control_if.master bus,
  output logic            illegal
);
  localparam int RIDX = $clog2(NREGS);

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [WIDTH_ALUF-1:0] ALU_ADD = '0;
  localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(8);
  localparam logic [NBITS-1:0]      FOUR    = NBITS'(4);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC} state_t;

  state_t           state_q;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [31:0]      ir_q;
  logic             req_q;
  logic             illegal_q;

  logic [31:0]           imm_i, imm_s, imm_b, imm_j, imm32;
  logic [NBITS-1:0]      pc_plus4;
  logic [WIDTH_ALUF-1:0] alu_ctl;
  logic                  alu_src, mem_to_reg, wr_en, st_en, lnk, legal;
  logic                  is_exec;

  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + FOUR;

  // Decode is purely from IR; only the enables and the PC update are qualified by EXEC.
  always_comb begin
    imm32      = '0;
    alu_ctl    = ALU_ADD;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    wr_en      = 1'b0;
    st_en      = 1'b0;
    lnk        = 1'b0;
    legal      = 1'b1;
    pc_d       = pc_plus4;
    case (ir_q[6:0])
      OP_ADDI: begin
        imm32   = imm_i;
        alu_src = 1'b1;
        wr_en   = 1'b1;
      end
      OP_ALU: begin
        alu_ctl = ir_q[30] ? ALU_SUB : ALU_ADD;
        wr_en   = 1'b1;
      end
      OP_LW: begin
        imm32      = imm_i;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        wr_en      = 1'b1;
      end
      OP_SW: begin
        imm32   = imm_s;
        alu_src = 1'b1;
        st_en   = 1'b1;
      end
      OP_BEQ: begin
        imm32   = imm_b;
        alu_ctl = ALU_SUB;
        if (bus.Zero) pc_d = pc_q + imm_b[NBITS-1:0];
      end
      OP_JAL: begin
        imm32 = imm_j;
        lnk   = 1'b1;
        wr_en = 1'b1;
        pc_d  = pc_q + imm_j[NBITS-1:0];
      end
      OP_JALR: begin
        imm32 = imm_i;
        lnk   = 1'b1;
        wr_en = 1'b1;
        pc_d  = (bus.PCReg + imm_i[NBITS-1:0]) & ~NBITS'(1);
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      req_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          req_q   <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            ir_q    <= bus.imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc_q    <= pc_d;
          if (!legal) illegal_q <= 1'b1;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign is_exec = (state_q == S_EXEC);

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.RS1        = ir_q[15 +: RIDX];
  assign bus.RS2        = ir_q[20 +: RIDX];
  assign bus.RD         = ir_q[7 +: RIDX];
  assign bus.IMM        = imm32[NBITS-1:0];
  assign bus.ALUControl = alu_ctl;
  assign bus.ALUSrc     = alu_src;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = is_exec & wr_en;
  assign bus.MemWrite   = is_exec & st_en;
  assign bus.link       = is_exec & lnk;
  assign bus.pclink     = pc_plus4;
  assign illegal        = illegal_q;

  // funct3 is not needed by this subset; upper immediate bits fall outside the datapath width
  logic unused_bits;
  assign unused_bits = ^{ir_q[14:12], imm32[31:NBITS]};
endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed instruction table, reset-in-WAIT sequence,
// then random instructions against a PC/decode reference model.
module tb_fetch_control;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic illegal;
  int   checks = 0;
  int   errors = 0;

  fetch_control_if #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) bus();

  fetch_control #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    bit          zero;
    logic [7:0]  pcreg;
    int          delay;
    bit          spur;
    logic [7:0]  addr;
    logic [4:0]  rd;
    logic [7:0]  imm;
    bit          imm_chk;
    logic [3:0]  aluc;
    logic [4:0]  flags;    // {ALUSrc, MemtoReg, RegWrite, MemWrite, link}
    logic [7:0]  pclink;
    logic [7:0]  next_addr;
    bit          ill;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input bit zero, input logic [7:0] pcreg,
                              input int delay, input logic [7:0] addr, input logic [4:0] rd,
                              input logic [7:0] imm, input bit imm_chk, input logic [3:0] aluc,
                              input logic [4:0] flags, input logic [7:0] pclink,
                              input logic [7:0] next_addr, input bit ill);
    vec_t v;
    v.instr = instr; v.zero = zero; v.pcreg = pcreg; v.delay = delay; v.spur = 1'b0;
    v.addr = addr; v.rd = rd; v.imm = imm; v.imm_chk = imm_chk; v.aluc = aluc;
    v.flags = flags; v.pclink = pclink; v.next_addr = next_addr; v.ill = ill;
    return v;
  endfunction

  // Reference model: spec rules with integer arithmetic, PC modulo 256.
  function automatic vec_t model(input logic [31:0] instr, input bit zero, input logic [7:0] pcreg,
                                 input int pc, input bit ill_in);
    vec_t v;
    int ii, si, bi, ji;
    ii = int'($signed(instr[31:20]));
    si = int'($signed({instr[31:25], instr[11:7]}));
    bi = int'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    ji = int'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    v = mk(instr, zero, pcreg, 0, 8'(pc), instr[11:7], 8'h00, 1'b1, 4'd0, 5'b00000,
           8'((pc + 4) % 256), 8'((pc + 4) % 256), ill_in);
    case (instr[6:0])
      7'b0010011: begin v.imm = 8'(ii & 255); v.flags = 5'b10100; end
      7'b0110011: begin v.imm_chk = 1'b0; v.aluc = instr[30] ? 4'd8 : 4'd0; v.flags = 5'b00100; end
      7'b0000011: begin v.imm = 8'(ii & 255); v.flags = 5'b11100; end
      7'b0100011: begin v.imm = 8'(si & 255); v.flags = 5'b10010; end
      7'b1100011: begin
        v.imm = 8'(bi & 255); v.aluc = 4'd8;
        if (zero) v.next_addr = 8'((pc + bi) & 255);
      end
      7'b1101111: begin
        v.imm = 8'(ji & 255); v.flags = 5'b00101; v.next_addr = 8'((pc + ji) & 255);
      end
      7'b1100111: begin
        v.imm = 8'(ii & 255); v.flags = 5'b00101;
        v.next_addr = 8'(((int'(pcreg) + ii) & 255) & 254);
      end
      default: begin v.imm_chk = 1'b0; v.ill = 1'b1; end
    endcase
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    bus.imem_ack = 1'b0;
    chk("req_wait_bound", 32'(n < 20), 32'd1);
    chk("fetch_addr", bus.imem_addr, v.addr);
    for (int i = 0; i < v.delay; i++) @(negedge clock);
    chk("addr_stable_wait", {bus.imem_req, bus.imem_addr}, {1'b1, v.addr});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.instr;
    bus.Zero       = v.zero;
    bus.PCReg      = v.pcreg;
    @(negedge clock);
    bus.imem_ack   = 1'b0;
    chk("exec_req_low", bus.imem_req, 1'b0);
    chk("RS1", bus.RS1, v.instr[19:15]);
    chk("RS2", bus.RS2, v.instr[24:20]);
    chk("RD", bus.RD, v.rd);
    if (v.imm_chk) chk("IMM", bus.IMM, v.imm);
    chk("ALUControl", bus.ALUControl, v.aluc);
    chk("flags", {bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemWrite, bus.link}, v.flags);
    chk("pclink", bus.pclink, v.pclink);
    @(negedge clock);
    chk("next_addr", bus.imem_addr, v.next_addr);
    chk("post_exec_enables", {bus.imem_req, bus.RegWrite, bus.MemWrite, bus.link}, 4'b0000);
    chk("illegal", illegal, v.ill);
    if (v.spur) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = $urandom;
    end
  endtask

  vec_t       tbl[14];
  logic [6:0] ops[8];
  vec_t       rv;
  int         m_pc;
  bit         m_ill;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    //          instr         Z  PCReg  dly addr   rd     imm   ic aluc flags     pclink next   ill
    tbl[0]  = mk(32'h00500093, 0, 8'h00, 3, 8'h00, 5'd1,  8'h05, 1, 4'd0, 5'b10100, 8'h04, 8'h04, 0);
    tbl[1]  = mk(32'h002081B3, 0, 8'h00, 0, 8'h04, 5'd3,  8'h00, 0, 4'd0, 5'b00100, 8'h08, 8'h08, 0);
    tbl[2]  = mk(32'h00208463, 0, 8'h00, 1, 8'h08, 5'd8,  8'h08, 1, 4'd8, 5'b00000, 8'h0C, 8'h0C, 0);
    tbl[3]  = mk(32'hFFDFF0EF, 0, 8'h00, 2, 8'h0C, 5'd1,  8'hFC, 1, 4'd0, 5'b00101, 8'h10, 8'h08, 0);
    tbl[4]  = mk(32'h00208463, 1, 8'h00, 0, 8'h08, 5'd8,  8'h08, 1, 4'd8, 5'b00000, 8'h0C, 8'h10, 0);
    tbl[5]  = mk(32'h002302E7, 0, 8'h21, 1, 8'h10, 5'd5,  8'h02, 1, 4'd0, 5'b00101, 8'h14, 8'h22, 0);
    tbl[6]  = mk(32'hFFD12383, 0, 8'h00, 0, 8'h22, 5'd7,  8'hFD, 1, 4'd0, 5'b11100, 8'h26, 8'h26, 0);
    tbl[7]  = mk(32'h0030AA23, 0, 8'h00, 2, 8'h26, 5'd20, 8'h14, 1, 4'd0, 5'b10010, 8'h2A, 8'h2A, 0);
    tbl[8]  = mk(32'h40208233, 0, 8'h00, 0, 8'h2A, 5'd4,  8'h00, 0, 4'd8, 5'b00100, 8'h2E, 8'h2E, 0);
    tbl[9]  = mk(32'h00000073, 0, 8'h00, 1, 8'h2E, 5'd0,  8'h00, 0, 4'd0, 5'b00000, 8'h32, 8'h32, 1);
    tbl[10] = mk(32'h00500093, 0, 8'h00, 0, 8'h32, 5'd1,  8'h05, 1, 4'd0, 5'b10100, 8'h36, 8'h36, 1);
    tbl[11] = mk(32'h00030067, 0, 8'hFC, 0, 8'h36, 5'd0,  8'h00, 1, 4'd0, 5'b00101, 8'h3A, 8'hFC, 1);
    tbl[12] = mk(32'h00500093, 0, 8'h00, 1, 8'hFC, 5'd1,  8'h05, 1, 4'd0, 5'b10100, 8'h00, 8'h00, 1);
    tbl[13] = mk(32'hFFF080E7, 0, 8'h10, 0, 8'h00, 5'd1,  8'hFF, 1, 4'd0, 5'b00101, 8'h04, 8'h0E, 1);

    ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b0000011; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1100111; ops[7] = 7'b1110011;

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.Zero       = 1'b0;
    bus.PCReg      = '0;

    @(negedge clock);
    chk("rst_outputs", {bus.imem_req, bus.RegWrite, bus.MemWrite, bus.link, bus.ALUSrc,
                        bus.MemtoReg, illegal}, 7'b0000000);
    chk("rst_pc", bus.imem_addr, 8'h00);
    chk("rst_ir_fields", {bus.RD, bus.IMM, bus.ALUControl}, 17'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[k]) run_vec(tbl[k]);

    // Reset while a fetch is outstanding at a non-zero PC, with ack asserted across release.
    @(negedge clock);
    chk("pre_rst_wait", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h0E});
    reset = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h00500093;
    #1;
    chk("midwait_rst_req", bus.imem_req, 1'b0);
    chk("midwait_rst_pc", bus.imem_addr, 8'h00);
    chk("midwait_rst_illegal", illegal, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    bus.imem_ack = 1'b0;
    chk("post_rst_ack_ignored", {bus.imem_req, bus.RegWrite, bus.imem_addr}, {1'b1, 1'b0, 8'h00});

    m_pc  = 0;
    m_ill = 1'b0;
    for (int r = 0; r < 80; r++) begin
      logic [31:0] ins;
      ins      = $urandom;
      ins[6:0] = ops[$urandom_range(7, 0)];
      rv = model(ins, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), m_pc, m_ill);
      rv.delay = $urandom_range(3, 0);
      rv.spur  = 1'($urandom_range(1, 0));
      run_vec(rv);
      m_pc  = int'(rv.next_addr);
      m_ill = rv.ill;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
